banked_mem_unit: RTL and testbench

Parametrised data-memory unit for the memory stage. It holds LANES byte-wide banks and serves byte, halfword and word loads and stores at any byte address. Unaligned accesses, including those that span two bank rows, complete in a single bank access. A valid/ready request and response handshake decouples the unit from the execute/memory pipeline register, and load data is sign- or zero-extended before it is returned for writeback.

---
 rtl/banked_mem_unit.sv | 190 +++++++++++++++++++
 tb/tb_banked_mem_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_unit.sv
// banked_mem_unit: LANES byte-wide banks serving byte/half/word loads and
// stores at any byte address, with valid/ready request/response handshakes.
// Optional build macro MEM_MISALIGN_TRAP_EN: when defined, legal-size accesses
// whose address is not a multiple of the access size are rejected with resp_err.
// Supported range: LANES power of two in 2..8, log2(LANES)+BANK_AW < 32.
`timescale 1ns/1ps

module banked_mem_unit #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned BANK_AW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_code,
    input  logic [31:0]          req_addr,
    input  logic [8*LANES-1:0]   req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [8*LANES-1:0]   resp_rdata,
    output logic                 resp_err
);

    localparam int unsigned DW    = 8 * LANES;
    localparam int unsigned LOG_L = $clog2(LANES);
    localparam int unsigned DEPTH = 1 << BANK_AW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t state;

    // Request fields captured on acceptance
    logic [LOG_L-1:0] off_q;
    logic [1:0]       size_q;
    logic             uns_q;

    // Request decode
    logic               is_store_c;
    logic [LOG_L-1:0]   off_c;
    logic [BANK_AW-1:0] base_row_c;
    logic [31:0]        nbytes_c;
    logic               size_bad_c;
    logic               misalign_c;
    logic               reject_c;
    logic               accept_c;
    logic               mem_we_c;
    logic               mem_re_c;

    assign is_store_c = req_code[0];
    assign off_c      = req_addr[LOG_L-1:0];
    assign base_row_c = req_addr[LOG_L +: BANK_AW];
    assign nbytes_c   = 32'd1 << req_code[2:1];
    assign size_bad_c = 32'(req_code[2:1]) > LOG_L;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_c = !size_bad_c && ((off_c & LOG_L'(nbytes_c - 32'd1)) != '0);
`else
    assign misalign_c = 1'b0;
`endif

    assign reject_c  = size_bad_c | misalign_c;
    assign accept_c  = (state == IDLE) && req_valid;
    assign mem_we_c  = accept_c && is_store_c && !reject_c && !reset;
    assign mem_re_c  = accept_c && !is_store_c && !reject_c;
    assign req_ready = (state == IDLE);

    // High address bits and the reserved code bit are intentionally ignored
    logic unused_c;
    assign unused_c = ^{req_code[4], req_addr[31:LOG_L+BANK_AW]};

    // Per-bank row, write enable and write byte from address rotation
    logic [BANK_AW-1:0] bank_row_c   [LANES];
    logic [7:0]         bank_wbyte_c [LANES];
    logic [LANES-1:0]   bank_we_c;

    always_comb begin
        logic [LOG_L-1:0] lane;
        bank_we_c = '0;
        for (int unsigned b = 0; b < LANES; b++) begin
            bank_row_c[b]   = '0;
            bank_wbyte_c[b] = '0;
        end
        for (int unsigned b = 0; b < LANES; b++) begin
            lane            = LOG_L'(b) - off_c;
            bank_row_c[b]   = (LOG_L'(b) < off_c) ? base_row_c + BANK_AW'(1) : base_row_c;
            bank_wbyte_c[b] = req_wdata[lane*8 +: 8];
            bank_we_c[b]    = mem_we_c && (32'(lane) < nbytes_c);
        end
    end

    // Byte banks: write on the acceptance edge, registered read for loads
    logic [DW-1:0] rd_bus;

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Bank storage with synchronous read
        always_ff @(posedge clk) begin
            if (bank_we_c[g]) begin
                mem[bank_row_c[g]] <= bank_wbyte_c[g];
            end
            if (mem_re_c) begin
                rd_q <= mem[bank_row_c[g]];
            end
        end

        assign rd_bus[g*8 +: 8] = rd_q;
    end

    // Load assembly: rotate by the byte offset, mask to size, extend
    logic [DW-1:0] rot_c;
    logic [DW-1:0] ext_c;
    logic          sign_c;

    always_comb begin
        logic [LOG_L-1:0] idx;
        int unsigned      sb;
        rot_c  = '0;
        ext_c  = '0;
        sign_c = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            idx               = off_q + LOG_L'(i);
            rot_c[i*8 +: 8]   = rd_bus[idx*8 +: 8];
        end
        sb = (32'd8 << size_q) - 32'd1;
        if (sb < DW) begin
            sign_c = rot_c[sb];
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < (32'd1 << size_q)) begin
                ext_c[i*8 +: 8] = rot_c[i*8 +: 8];
            end else begin
                ext_c[i*8 +: 8] = (uns_q) ? 8'h00 : {8{sign_c}};
            end
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q  <= off_c;
                        size_q <= req_code[2:1];
                        uns_q  <= req_code[3];
                        if (reject_c || is_store_c) begin
                            resp_valid <= 1'b1;
                            resp_err   <= reject_c;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            state <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    resp_rdata <= ext_c;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_mem_unit.sv
// Directed bench for banked_mem_unit (LANES=4, BANK_AW=16).
`timescale 1ns/1ps

module tb_banked_mem_unit;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 8 * LANES;

    localparam logic [4:0] LB  = 5'h00;  // signed byte load
    localparam logic [4:0] LBU = 5'h08;
    localparam logic [4:0] LH  = 5'h02;
    localparam logic [4:0] LHU = 5'h0A;
    localparam logic [4:0] LW  = 5'h04;
    localparam logic [4:0] L8  = 5'h06;  // illegal size load
    localparam logic [4:0] SH  = 5'h03;
    localparam logic [4:0] SW  = 5'h05;
    localparam logic [4:0] S8  = 5'h07;  // illegal size store

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_code;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    int checks = 0;
    int errors = 0;

    banked_mem_unit #(.LANES(LANES), .BANK_AW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_code   (req_code),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One full request/response; lat = edges from acceptance (inclusive) to resp_valid
    task automatic xact(input logic [4:0] code, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_code   = code;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_code  = 5'h1F;
        req_addr  = 32'hDEAD_BEEF;
        req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = resp_rdata;
        err = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_code = '0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_word_round_trip;
        logic [31:0] rd; logic err; int lat;
        xact(SW, 32'h100, 32'hA1B2C3D4, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL store_word: lat=%0d err=%b rdata=%h, required lat=1 err=0 rdata=00000000", lat, err, rd);
        end
        xact(LW, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL load_word: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=a1b2c3d4", lat, err, rd);
        end
    endtask

    task automatic test_extension;
        logic [31:0] rd; logic err; int lat;
        xact(LB, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFFFD4 || err !== 1'b0) begin
            errors++;
            $display("FAIL lb_100: rdata=%h err=%b, required ffffffd4 0", rd, err);
        end
        xact(LBU, 32'h103, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h000000A1 || err !== 1'b0) begin
            errors++;
            $display("FAIL lbu_103: rdata=%h err=%b, required 000000a1 0", rd, err);
        end
        xact(LH, 32'h102, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFA1B2 || err !== 1'b0) begin
            errors++;
            $display("FAIL lh_102: rdata=%h err=%b, required ffffa1b2 0", rd, err);
        end
    endtask

    task automatic test_row_cross;
        logic [31:0] rd; logic err; int lat;
        xact(SW, 32'h104, 32'h0, rd, err, lat);
        xact(SW, 32'h108, 32'h0, rd, err, lat);
        xact(SH, 32'h107, 32'h1234BEEF, rd, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL sh_107: lat=%0d err=%b, required lat=1 err=0", lat, err);
        end
        xact(LW, 32'h104, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hEF000000) begin
            errors++;
            $display("FAIL lw_104: rdata=%h, required ef000000", rd);
        end
        xact(LW, 32'h108, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h000000BE) begin
            errors++;
            $display("FAIL lw_108: rdata=%h, required 000000be", rd);
        end
        xact(LHU, 32'h107, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000BEEF || lat !== 2) begin
            errors++;
            $display("FAIL lhu_107: rdata=%h lat=%0d, required 0000beef lat=2", rd, lat);
        end
        xact(LH, 32'h107, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFFBEEF) begin
            errors++;
            $display("FAIL lh_107: rdata=%h, required ffffbeef", rd);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic err; int lat;
        xact(SW, 32'h3FFFE, 32'h11223344, rd, err, lat);
        xact(LHU, 32'h0, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h00001122) begin
            errors++;
            $display("FAIL lhu_0: rdata=%h, required 00001122", rd);
        end
        xact(LHU, 32'h3FFFE, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h00003344) begin
            errors++;
            $display("FAIL lhu_3fffe: rdata=%h, required 00003344", rd);
        end
        xact(LW, 32'h3FFFE, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h11223344) begin
            errors++;
            $display("FAIL lw_3fffe: rdata=%h, required 11223344", rd);
        end
        xact(LHU, 32'h40000, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'h00001122) begin
            errors++;
            $display("FAIL lhu_alias_40000: rdata=%h, required 00001122", rd);
        end
    endtask

    task automatic test_backpressure;
        logic stable;
        logic [31:0] rd; logic err; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_code = LW; req_addr = 32'h100; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_load_wait_valid: valid=%b, required 0", resp_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA1B2C3D4 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp: valid=%b rdata=%h err=%b, required 1 a1b2c3d4 0",
                     resp_valid, resp_rdata, resp_err);
        end
        // offer a competing store that must not be taken
        req_valid = 1'b1; req_code = SW; req_addr = 32'h100; req_wdata = 32'h0;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hA1B2C3D4 || resp_err !== 1'b0 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: valid=%b rdata=%h err=%b ready=%b, required stable 1 a1b2c3d4 0 ready=0",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
        xact(LW, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hA1B2C3D4) begin
            errors++;
            $display("FAIL bp_no_overlap: rdata=%h, required a1b2c3d4", rd);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] rd; logic err; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_code = LW; req_addr = 32'h100; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_load_wait: valid=%b ready=%b rdata=%h, required 0 1 00000000",
                     resp_valid, req_ready, resp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        // store committed on acceptance, then reset in RESP
        @(negedge clk);
        req_valid = 1'b1; req_code = SW; req_addr = 32'h200; req_wdata = 32'hCAFEF00D; resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_resp_before_reset: valid=%b, required 1", resp_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_resp: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        xact(LW, 32'h200, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || err !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL after_reset_load: rdata=%h err=%b lat=%0d, required cafef00d 0 2", rd, err, lat);
        end
    endtask

    task automatic test_illegal_size;
        logic [31:0] rd; logic err; int lat;
        xact(S8, 32'h100, 32'hFFFFFFFF, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_store: err=%b rdata=%h lat=%0d, required 1 00000000 1", err, rd, lat);
        end
        xact(L8, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_load: err=%b rdata=%h lat=%0d, required 1 00000000 1", err, rd, lat);
        end
        xact(LW, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hA1B2C3D4 || err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_no_write: rdata=%h err=%b, required a1b2c3d4 0", rd, err);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic err; int lat;
        xact(SH, 32'h101, 32'h00005555, rd, err, lat);
`ifdef MEM_MISALIGN_TRAP_EN
        checks++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL trap_store: err=%b rdata=%h lat=%0d, required 1 00000000 1", err, rd, lat);
        end
        xact(LW, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hA1B2C3D4 || err !== 1'b0) begin
            errors++;
            $display("FAIL trap_no_write: rdata=%h err=%b, required a1b2c3d4 0", rd, err);
        end
        xact(LW, 32'h102, 32'h0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL trap_load: err=%b rdata=%h lat=%0d, required 1 00000000 1", err, rd, lat);
        end
`else
        checks++;
        if (err !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL misalign_store: err=%b lat=%0d, required 0 1", err, lat);
        end
        xact(LW, 32'h100, 32'h0, rd, err, lat);
        checks++;
        if (rd !== 32'hA15555D4 || err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_result: rdata=%h err=%b, required a15555d4 0", rd, err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_extension();
        test_row_cross();
        test_wrap();
        test_backpressure();
        test_reset_mid_op();
        test_illegal_size();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
